// File: rtl/downsample_pkg.sv
// Shared definitions for the downsampling sequencing controller:
// FSM state encoding and the post-reset decimation rate.
package downsample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int RATE_DEFAULT = 1;

endpackage

// File: rtl/downsample_ctrl_phase_counter.sv
// Modulo-rate up counter: advances on en, wraps at rate-1, clr forces zero.
// A rate of 1 keeps the count pinned at zero.
module phase_counter #(
  parameter int RATE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  clr,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [RATE_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == rate - 1'b1) count <= '0;
      else                      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/downsample_ctrl.sv
// Keeps one input sample in every rate_q, presenting kept samples through a
// one-entry output register, with run/stop/drain sequencing and an emit counter.
module downsample_ctrl
  import downsample_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATE_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [RATE_WIDTH-1:0] cfg_rate,
  input  logic                  cfg_load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [RATE_WIDTH-1:0] phase,
  output logic [CNT_WIDTH-1:0]  kept_count,
  output logic                  cfg_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producers hold valid/data until accepted; in_ready is combinational.
  state_t                state;
  logic [RATE_WIDTH-1:0] rate_q;
  logic                  accept;
  logic                  keep;
  logic                  consume;
  logic                  stop_to_idle;
  logic                  drain_done;
  logic                  phase_clr;

  // A kept sample may only land if the output register is free or emptying.
  assign in_ready = (state == ST_RUN) && !stop &&
                    ((phase != '0) || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign keep     = accept && (phase == '0);
  assign consume  = out_valid && out_ready;
  assign busy     = (state != ST_IDLE);

  assign stop_to_idle = (state == ST_RUN) && stop && (!out_valid || consume);
  assign drain_done   = (state == ST_DRAIN) && consume;
  assign phase_clr    = stop_to_idle || drain_done;

  phase_counter #(
    .RATE_WIDTH (RATE_WIDTH)
  ) u_phase (
    .clk    (clk),
    .resetn (resetn),
    .en     (accept),
    .clr    (phase_clr),
    .rate   (rate_q),
    .count  (phase)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !stop) state <= ST_RUN;
        end
        ST_RUN: begin
          if (stop) state <= (stop_to_idle) ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (consume) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rate_q  <= RATE_WIDTH'(RATE_DEFAULT);
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load && (state != ST_IDLE);
      if (cfg_load && (state == ST_IDLE))
        rate_q <= (cfg_rate == '0) ? RATE_WIDTH'(1) : cfg_rate;
    end
  end

  // Load wins over consume so back-to-back keeps stream at full rate.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (keep) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      kept_count <= '0;
    else if (consume) kept_count <= kept_count + 1'b1;
  end

endmodule

// File: tb/tb_downsample_ctrl.sv
// Directed bench for downsample_ctrl: table of streaming vectors plus
// hand-written sequences for backpressure, drain, config error and reset.
module tb_downsample_ctrl;

  logic       clk;
  logic       resetn;
  logic [7:0] cfg_rate;
  logic       cfg_load;
  logic       start;
  logic       stop;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [7:0] phase;
  logic [3:0] kept_count;
  logic       cfg_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  downsample_ctrl #(
    .DATA_WIDTH (8),
    .RATE_WIDTH (8),
    .CNT_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cfg_rate   (cfg_rate),
    .cfg_load   (cfg_load),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .phase      (phase),
    .kept_count (kept_count),
    .cfg_err    (cfg_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    resetn    = 1'b0;
    cfg_rate  = '0;
    cfg_load  = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the head of exp_q.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data_unexpected: got %0h expected none", out_data);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic load_rate(input logic [7:0] r);
    cfg_rate = r;
    cfg_load = 1'b1;
    @(posedge clk);
    #1 cfg_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] rate;
    logic [7:0] base;
    int         n;
    int         exp_kept;
    logic [7:0] exp_phase;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int eff;

    vecs[0] = '{rate: 8'd4,   base: 8'h00, n: 16,  exp_kept: 4, exp_phase: 8'd0};
    vecs[1] = '{rate: 8'd0,   base: 8'h10, n: 4,   exp_kept: 4, exp_phase: 8'd0};
    vecs[2] = '{rate: 8'd3,   base: 8'h40, n: 7,   exp_kept: 3, exp_phase: 8'd1};
    vecs[3] = '{rate: 8'd5,   base: 8'h80, n: 12,  exp_kept: 3, exp_phase: 8'd2};
    vecs[4] = '{rate: 8'd255, base: 8'h00, n: 256, exp_kept: 2, exp_phase: 8'd1};

    do_reset();
    check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    check("rst_out_data",   {24'd0, out_data},   32'd0);
    check("rst_kept_count", {28'd0, kept_count}, 32'd0);
    check("rst_cfg_err",    {31'd0, cfg_err},    32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_phase",      {24'd0, phase},      32'd0);
    check("rst_in_ready",   {31'd0, in_ready},   32'd0);

    // Continuous streams with out_ready held high.
    foreach (vecs[v]) begin
      do_reset();
      load_rate(vecs[v].rate);
      pulse_start();
      check("vec_busy", {31'd0, busy}, 32'd1);
      out_ready = 1'b1;
      eff = (vecs[v].rate == 8'd0) ? 1 : int'(vecs[v].rate);
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i % eff == 0) exp_q.push_back(8'(vecs[v].base + i));
        send(8'(vecs[v].base + i));
      end
      idle_cycles(3);
      check("vec_kept_count", {28'd0, kept_count}, 32'(vecs[v].exp_kept % 16));
      check("vec_phase",      {24'd0, phase},      {24'd0, vecs[v].exp_phase});
      check("vec_drained",    32'(exp_q.size()),   32'd0);
      stop = 1'b1;
      idle_cycles(1);
      stop = 1'b0;
      check("vec_stop_idle", {31'd0, busy}, 32'd0);
    end

    // Backpressure at R=3: third keep waits while the register is full.
    do_reset();
    load_rate(8'd3);
    pulse_start();
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h23);
    send(8'h20);
    send(8'h21);
    send(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h23;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_data",  {24'd0, out_data},  32'h20);
    check("bp_phase",     {24'd0, phase},     32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h23);
    send(8'h24);
    send(8'h25);
    idle_cycles(3);
    check("bp_kept_count", {28'd0, kept_count}, 32'd2);
    check("bp_phase_end",  {24'd0, phase},      32'd0);
    check("bp_drained",    32'(exp_q.size()),   32'd0);

    // Stop with a pending sample at R=2 goes through DRAIN.
    do_reset();
    load_rate(8'd2);
    pulse_start();
    send(8'h30);
    stop = 1'b1;
    @(negedge clk);
    check("stop_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 stop = 1'b0;
    check("drain_busy",      {31'd0, busy},      32'd1);
    check("drain_in_ready",  {31'd0, in_ready},  32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd1);
    check("drain_phase",     {24'd0, phase},     32'd1);
    exp_q.push_back(8'h30);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_done_busy",  {31'd0, busy},      32'd0);
    check("drain_done_valid", {31'd0, out_valid}, 32'd0);
    check("drain_done_phase", {24'd0, phase},     32'd0);

    // cfg_load while running is refused; rate stays at 2.
    pulse_start();
    load_rate(8'd7);
    check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
    idle_cycles(1);
    check("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
    exp_q.push_back(8'h50);
    exp_q.push_back(8'h52);
    for (int i = 0; i < 4; i++) send(8'(8'h50 + i));
    idle_cycles(3);
    check("cfg_rate_kept", {28'd0, kept_count}, 32'd3);
    start = 1'b1;
    stop  = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset with a sample pending.
    load_rate(8'd3);
    pulse_start();
    out_ready = 1'b0;
    send(8'h60);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_phase", {24'd0, phase},     32'd1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_phase", {24'd0, phase},     32'd0);
    check("async_rst_count", {28'd0, kept_count}, 32'd0);
    check("async_rst_busy",  {31'd0, busy},      32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // kept_count wraps: 17 emits on a 4-bit counter leaves 1.
    do_reset();
    load_rate(8'd1);
    pulse_start();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(8'(8'h70 + i));
      send(8'(8'h70 + i));
    end
    idle_cycles(3);
    check("wrap_kept_count", {28'd0, kept_count}, 32'd1);
    check("wrap_drained",    32'(exp_q.size()),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/downsample_ctrl.md
Name: downsample_ctrl

Overview:
- Sequencing controller for the downsampling datapath. Wraps a programmable phase counter: accepts an input sample stream with valid/ready handshakes, keeps one sample in every R, drops the rest, and presents kept samples on an output valid/ready port through a one-entry output register.
- Handles run/stop sequencing, decimation-rate configuration and a wrapping count of emitted samples.
- Sits between the sample source and the downstream filter/storage stage.

Parameters:
- DATA_WIDTH, 8, width of in_data/out_data.
- RATE_WIDTH, 8, width of cfg_rate and of the phase counter.
- CNT_WIDTH, 16, width of kept_count.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cfg_rate  in  RATE_WIDTH  decimation factor R; 0 is treated as 1.
- cfg_load  in  1  one-cycle strobe; latches cfg_rate into rate_q.
- start  in  1  one-cycle strobe; begin decimation.
- stop  in  1  one-cycle strobe; end decimation.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid and in_ready.
- in_data  in  DATA_WIDTH  input sample.
- out_valid  out  1  kept sample available.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  kept sample.
- busy  out  1  state != IDLE.
- phase  out  RATE_WIDTH  current phase counter value.
- kept_count  out  CNT_WIDTH  samples emitted since reset; wraps modulo 2^CNT_WIDTH.
- cfg_err  out  1  one-cycle pulse when cfg_load arrives outside IDLE.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, rate_q=1, phase=0.
  - out_valid=0, out_data=0, kept_count=0, cfg_err=0.
  - Reset mid-operation discards any pending output sample.
- States:
  - IDLE → RUN on start.
  - RUN → IDLE on stop if the output register is empty, or is being consumed that cycle. Otherwise RUN → DRAIN.
  - DRAIN → IDLE on the cycle out_valid && out_ready.
  - stop has priority over a simultaneous start.
  - start in RUN or DRAIN is ignored. stop in IDLE is ignored.
- Configuration:
  - cfg_load in IDLE: rate_q <= (cfg_rate==0) ? 1 : cfg_rate, on the next edge.
  - cfg_load in RUN or DRAIN: ignored; cfg_err=1 for exactly the following cycle.
- Input handshake:
  - in_ready = (state==RUN) && (phase!=0 || !out_valid || out_ready). Combinational.
  - Dropped samples are never back-pressured in RUN.
  - in_ready=0 in IDLE and DRAIN, including the cycle a stop is sampled.
- Phase counter:
  - Advances only on an accepted input: phase <= (phase==rate_q-1) ? 0 : phase+1.
  - phase=0 on entry to IDLE.
  - With rate_q=1, phase stays 0 and every sample is kept.
- Keep/drop:
  - An accepted sample with phase==0 is kept. Next edge: out_data <= in_data, out_valid <= 1. Latency 1 cycle.
  - An accepted sample with phase!=0 is dropped.
- Output:
  - out_valid clears when out_valid && out_ready and no new kept sample is loaded the same cycle.
  - Simultaneous consume and load: out_valid stays 1 and out_data takes the new sample. Full throughput at R=1.
  - out_data holds its value while out_valid=0 and is not otherwise cleared.
- kept_count:
  - Increments by 1 on every out_valid && out_ready.
  - Wraps from 2^CNT_WIDTH-1 to 0.
- Rate boundary: rate_q=2^RATE_WIDTH-1 is legal; phase wraps from rate_q-1 to 0.

Decomposition:
- Shared package downsample_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2;
  - the default rate constant RATE_DEFAULT=1.
- One natural sub-module: phase_counter.
  - Function: modulo-rate_q up counter with enable and synchronous clear.
  - Ports: clk, resetn, en, clr, rate, count.
  - Instantiated once.
- Handshake and FSM logic stay in the top module.

Test Plan:
- Reset then cfg_rate=4, cfg_load, start; feed 0x00..0x0F continuously with out_ready=1 → out_data sequence 0x00,0x04,0x08,0x0C; kept_count=4; phase=0 at end.
- cfg_rate=0 load, start, feed 0x10..0x13 → all four emitted; rate treated as 1.
- R=3, out_ready=0; feed 0x20..0x25 → 0x20 held in the output register, 0x21 and 0x22 accepted and dropped, in_ready=0 while phase==0 and out_valid=1. Raise out_ready → 0x20 then 0x23 emitted.
- R=2; stop asserted while out_valid=1 and out_ready=0 → state DRAIN, busy=1, in_ready=0. Raise out_ready → sample consumed, IDLE next cycle, busy=0, phase=0.
- cfg_load in RUN with cfg_rate=7 → rate unchanged (still 2), cfg_err=1 for one cycle. Simultaneous start+stop in RUN → returns to IDLE.
- Assert resetn=0 mid-stream with out_valid=1 → immediately out_valid=0, phase=0, kept_count=0, state IDLE. kept_count wrap check with CNT_WIDTH=4: 17 emitted samples → kept_count=1.
